// File: rtl/mux2x1_arbiter.sv
// Two-source round-robin arbiter with a registered select and shared output mux.
// A grant is released on a last beat, on a dropped request, or when the beat limit is reached.
module mux2x1_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAXBEATS = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             last0,
  input  logic             last1,
  input  logic             y_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             y_last,
  output logic             busy,
  output logic             abort
);

  localparam int unsigned    CW      = (MAXBEATS > 2) ? $clog2(MAXBEATS) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAXBEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_s, w_s_nxt;
  logic          r_rr, w_rr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_abort, w_abort_nxt;

  logic w_own_req;
  logic w_own_last;
  logic w_oth_req;
  logic w_xfer;
  logic w_release;
  logic w_grant0;
  logic w_grant1;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_s     <= 1'b0;
      r_rr    <= 1'b1;
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_rr    <= w_rr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_oth_req  = 1'b0;
    case (r_state)
      OWN0: begin
        w_own_req  = req0;
        w_own_last = last0;
        w_oth_req  = req1;
      end
      OWN1: begin
        w_own_req  = req1;
        w_own_last = last1;
        w_oth_req  = req0;
      end
      default: ;
    endcase
  end

  assign w_xfer = w_own_req & y_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = 1'b0;
    w_release   = 1'b0;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;

    case (r_state)
      IDLE: begin
        // On a tie rr names the last owner, so the other side wins.
        if (req0 && (!req1 || r_rr)) begin
          w_grant0 = 1'b1;
        end else if (req1) begin
          w_grant1 = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (w_xfer && w_own_last) begin
          w_release = 1'b1;
        end else if (!w_own_req) begin
          w_release   = 1'b1;
          w_abort_nxt = 1'b1;
        end else if (w_xfer) begin
          if (r_cnt == CNT_MAX) begin
            w_release   = 1'b1;
            w_abort_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A releasing owner may only hand over to the other side, never back to itself.
    if (w_release) begin
      if (w_oth_req) begin
        w_grant0 = (r_state == OWN1);
        w_grant1 = (r_state == OWN0);
      end else begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    end

    if (w_grant0) begin
      w_state_nxt = OWN0;
      w_s_nxt     = 1'b0;
      w_rr_nxt    = 1'b0;
      w_cnt_nxt   = '0;
    end else if (w_grant1) begin
      w_state_nxt = OWN1;
      w_s_nxt     = 1'b1;
      w_rr_nxt    = 1'b1;
      w_cnt_nxt   = '0;
    end
  end

  assign gnt0    = (r_state == OWN0);
  assign gnt1    = (r_state == OWN1);
  assign s       = r_s;
  assign y       = r_s ? d1 : d0;
  assign y_valid = w_own_req;
  assign y_last  = w_own_req & w_own_last;
  assign busy    = (r_state != IDLE);
  assign abort   = r_abort;

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Scoreboard bench for mux2x1_arbiter: bursts from two modelled requesters,
// expected beats queued in the order the arbitration rules dictate.
module tb_mux2x1_arbiter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         clrn, req0, req1, last0, last1, y_ready;
  logic [W-1:0] d0, d1, y;
  logic         gnt0, gnt1, s, y_valid, y_last, busy, abort;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t       sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  bit          src_act[2];
  int unsigned src_beats[2];
  int unsigned src_idx[2];
  int unsigned src_bursts[2];

  always #5 clk = ~clk;

  mux2x1_arbiter #(.WIDTH(W), .MAXBEATS(4)) dut (
    .clk(clk), .clrn(clrn), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .last0(last0), .last1(last1), .y_ready(y_ready), .gnt0(gnt0), .gnt1(gnt1),
    .s(s), .y(y), .y_valid(y_valid), .y_last(y_last), .busy(busy), .abort(abort)
  );

  function automatic logic src_last(int i);
    return src_act[i] && (src_beats[i] != 0) && ((src_idx[i] % src_beats[i]) == src_beats[i] - 1);
  endfunction

  task automatic drive_src();
    req0  = src_act[0];
    req1  = src_act[1];
    d0    = 32'hA000_0000 + src_idx[0];
    d1    = 32'hB000_0000 + src_idx[1];
    last0 = src_last(0);
    last1 = src_last(1);
  endtask

  task automatic start_src(int i, int unsigned beats, int unsigned bursts);
    src_act[i]    = 1'b1;
    src_beats[i]  = beats;
    src_bursts[i] = bursts;
    src_idx[i]    = 0;
    drive_src();
  endtask

  task automatic stop_src(int i);
    src_act[i] = 1'b0;
    drive_src();
  endtask

  task automatic adv(int i);
    if (src_last(i)) begin
      src_bursts[i]--;
      if (src_bursts[i] == 0) src_act[i] = 1'b0;
    end
    src_idx[i]++;
  endtask

  task automatic push_exp(int i, int unsigned idx, logic last);
    beat_t b;
    b.data = ((i == 0) ? 32'hA000_0000 : 32'hB000_0000) + idx;
    b.last = last;
    sb.push_back(b);
  endtask

  // One clock: note handshakes before the edge, then advance the requesters after it.
  task automatic step();
    bit x0, x1;
    @(negedge clk);
    x0 = gnt0 && req0 && y_ready;
    x1 = gnt1 && req1 && y_ready;
    @(posedge clk);
    #1;
    if (x0) adv(0);
    if (x1) adv(1);
    drive_src();
  endtask

  always @(negedge clk) begin
    tests++;
    if (gnt0 && gnt1) begin
      fails++;
      $display("FAIL grant_onehot gnt0=%b gnt1=%b want not both", gnt0, gnt1);
    end
    if (y_valid && y_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected y=%h y_last=%b want no beat", y, y_last);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({y, y_last} !== e) begin
          fails++;
          $display("FAIL sb_beat y=%h y_last=%b want y=%h y_last=%b", y, y_last, e.data, e.last);
        end
      end
    end
  end

  task automatic test_reset();
    logic [4:0] obs;
    clrn = 1'b0; y_ready = 1'b1;
    start_src(0, 0, 1);
    start_src(1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      step();
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== 5'b00000 || y_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold[%0d] ctrl=%b y_valid=%b want 00000 0", k, obs, y_valid);
      end
    end
    stop_src(0); stop_src(1);
    clrn = 1'b1;
    step();
    obs = {gnt0, gnt1, s, busy, abort};
    tests++;
    if (obs !== 5'b00000) begin
      fails++;
      $display("FAIL reset_idle ctrl=%b want 00000", obs);
    end
  endtask

  task automatic test_single_burst();
    logic [4:0] obs;
    logic [4:0] exp_v [4] = '{5'b10010, 5'b10010, 5'b10010, 5'b00000};
    start_src(0, 3, 1);
    push_exp(0, 0, 1'b0); push_exp(0, 1, 1'b0); push_exp(0, 2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== exp_v[k]) begin
        fails++;
        $display("FAIL single_ctrl[%0d] got %b want %b", k, obs, exp_v[k]);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL single_drain left=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic [4:0] exp_v [9] = '{5'b10010, 5'b10010, 5'b01110, 5'b01110, 5'b10010,
                              5'b10010, 5'b01110, 5'b01110, 5'b00100};
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    start_src(0, 2, 2);
    start_src(1, 2, 2);
    for (int unsigned b = 0; b < 2; b++) begin
      push_exp(0, 2*b, 1'b0); push_exp(0, 2*b+1, 1'b1);
      push_exp(1, 2*b, 1'b0); push_exp(1, 2*b+1, 1'b1);
    end
    for (int k = 0; k < 9; k++) begin
      step();
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== exp_v[k]) begin
        fails++;
        $display("FAIL b2b_ctrl[%0d] got %b want %b", k, obs, exp_v[k]);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain left=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_stall();
    logic [4:0] obs;
    start_src(1, 3, 1);
    push_exp(1, 0, 1'b0); push_exp(1, 1, 1'b0); push_exp(1, 2, 1'b1);
    step(); step();
    y_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== 5'b01110 || y !== 32'hB000_0001 || y_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d] ctrl=%b y=%h y_valid=%b want 01110 b0000001 1", k, obs, y, y_valid);
      end
    end
    y_ready = 1'b1;
    step();
    obs = {gnt0, gnt1, s, busy, abort};
    tests++;
    if (obs !== 5'b01110) begin
      fails++;
      $display("FAIL stall_resume ctrl=%b want 01110", obs);
    end
    step();
    obs = {gnt0, gnt1, s, busy, abort};
    tests++;
    if (obs !== 5'b00100) begin
      fails++;
      $display("FAIL stall_end ctrl=%b want 00100", obs);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stall_drain left=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_maxbeats();
    logic [4:0] obs;
    logic [4:0] exp_v [7] = '{5'b10010, 5'b10010, 5'b10010, 5'b10010,
                              5'b01111, 5'b01110, 5'b00100};
    start_src(0, 0, 1);
    for (int unsigned i = 0; i < 4; i++) push_exp(0, i, 1'b0);
    push_exp(1, 0, 1'b0); push_exp(1, 1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) start_src(1, 2, 1);
      if (k == 4) stop_src(0);
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== exp_v[k]) begin
        fails++;
        $display("FAIL maxbeats_ctrl[%0d] got %b want %b", k, obs, exp_v[k]);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL maxbeats_drain left=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_abort_drop();
    logic [4:0] obs;
    logic [4:0] exp_a [4] = '{5'b01110, 5'b01110, 5'b00101, 5'b00100};
    logic [4:0] exp_b [5] = '{5'b01110, 5'b01110, 5'b10011, 5'b10010, 5'b00000};
    start_src(1, 0, 1);
    push_exp(1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 1) stop_src(1);
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== exp_a[k]) begin
        fails++;
        $display("FAIL drop_idle_ctrl[%0d] got %b want %b", k, obs, exp_a[k]);
      end
    end
    start_src(1, 0, 1);
    push_exp(1, 0, 1'b0);
    push_exp(0, 0, 1'b0); push_exp(0, 1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) begin
        stop_src(1);
        start_src(0, 2, 1);
      end
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== exp_b[k]) begin
        fails++;
        $display("FAIL drop_handoff_ctrl[%0d] got %b want %b", k, obs, exp_b[k]);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drop_drain left=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    logic [4:0] exp_a [7] = '{5'b01110, 5'b01110, 5'b00000, 5'b10010, 5'b10010, 5'b01110, 5'b00100};
    logic [4:0] exp_b [6] = '{5'b10010, 5'b10010, 5'b00000, 5'b10010, 5'b01110, 5'b00100};
    start_src(1, 0, 1);
    push_exp(1, 0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 1) begin
        clrn = 1'b0; y_ready = 1'b0;
        start_src(0, 2, 1);
        start_src(1, 1, 1);
      end
      if (k == 2) begin
        tests++;
        if (y_valid !== 1'b0) begin
          fails++;
          $display("FAIL rstmid1_yvalid got %b want 0", y_valid);
        end
        clrn = 1'b1; y_ready = 1'b1;
        push_exp(0, 0, 1'b0); push_exp(0, 1, 1'b1); push_exp(1, 0, 1'b1);
      end
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== exp_a[k]) begin
        fails++;
        $display("FAIL rstmid1_ctrl[%0d] got %b want %b", k, obs, exp_a[k]);
      end
    end
    // Reset during OWN0 must restore rr so that requester 0 still wins the tie.
    start_src(0, 0, 1);
    push_exp(0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 1) begin
        clrn = 1'b0; y_ready = 1'b0;
        start_src(0, 1, 1);
        start_src(1, 1, 1);
      end
      if (k == 2) begin
        tests++;
        if (y_valid !== 1'b0) begin
          fails++;
          $display("FAIL rstmid2_yvalid got %b want 0", y_valid);
        end
        clrn = 1'b1; y_ready = 1'b1;
        push_exp(0, 0, 1'b1); push_exp(1, 0, 1'b1);
      end
      obs = {gnt0, gnt1, s, busy, abort};
      tests++;
      if (obs !== exp_b[k]) begin
        fails++;
        $display("FAIL rstmid2_ctrl[%0d] got %b want %b", k, obs, exp_b[k]);
      end
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL rstmid_drain left=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    src_act[0] = 1'b0; src_act[1] = 1'b0;
    src_idx[0] = 0;    src_idx[1] = 0;
    src_beats[0] = 0;  src_beats[1] = 0;
    src_bursts[0] = 0; src_bursts[1] = 0;
    clrn = 1'b0; y_ready = 1'b1;
    drive_src();
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_stall();
    test_maxbeats();
    test_abort_drop();
    test_reset_mid();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
